// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit miss tracker: slot FSM states,
// screen geometry defaults and a popcount helper.
package fruit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    CUT,
    MISSED
  } slot_state_t;

  localparam int SCREEN_H    = 480;
  localparam int FLOOR_Y_DEF = 490;
  localparam int CNT_MAX_DEF = 255;
  localparam int Y_W         = 10;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fruit_miss_tracker_if.sv
// Fruit-slot inputs and miss-count outputs between the fruit block (master)
// and the miss tracker (slave).
interface fruit_miss_tracker_if #(
  parameter int F = 4
);
  logic             frame_clk_rising_edge;
  logic [F-1:0]     fruit_active;
  logic [F-1:0]     fruit_cut;
  logic [F*10-1:0]  fruit_y;
  logic [31:0]      miss_num;
  logic             miss_pulse;
  logic [F-1:0]     miss_vec;

  modport master (
    output frame_clk_rising_edge, fruit_active, fruit_cut, fruit_y,
    input  miss_num, miss_pulse, miss_vec
  );

  modport slave (
    input  frame_clk_rising_edge, fruit_active, fruit_cut, fruit_y,
    output miss_num, miss_pulse, miss_vec
  );
endinterface

// File: rtl/fruit_miss_tracker_slot_fsm.sv
// Per-slot lifecycle FSM. Flags new_miss combinationally in the frame-edge
// cycle where an uncut flying fruit first reaches the floor.
module miss_slot_fsm
  import fruit_pkg::*;
#(
  parameter int FLOOR_Y = FLOOR_Y_DEF
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Initialize,
  input  logic           frame_edge,
  input  logic           fruit_active,
  input  logic           fruit_cut,
  input  logic [Y_W-1:0] fruit_y,
  output logic           new_miss
);

  localparam logic [Y_W-1:0] FLOOR_LIM = Y_W'(FLOOR_Y);

  slot_state_t state_q, state_d;

  // NOTE: state and outputs get a default before the case so every path
  // assigns them; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    new_miss = 1'b0;
    if (frame_edge) begin
      case (state_q)
        IDLE: begin
          // A fruit launched already below the floor is judged next frame.
          if (fruit_active) state_d = FLYING;
        end
        FLYING: begin
          if (fruit_cut) begin
            state_d = CUT;
          end else if (fruit_y >= FLOOR_LIM) begin
            state_d  = MISSED;
            new_miss = 1'b1;
          end else if (!fruit_active) begin
            state_d = IDLE;
          end
        end
        CUT, MISSED: begin
          if (!fruit_active) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else if (Initialize) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/fruit_miss_tracker.sv
// Counts fruits that fall past the floor uncut: one FSM per slot feeding a
// popcount and a saturating cumulative miss counter sampled per frame.
module fruit_miss_tracker
  import fruit_pkg::*;
#(
  parameter int F       = 4,
  parameter int FLOOR_Y = FLOOR_Y_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Initialize,
  fruit_miss_tracker_if.slave bus
);

  localparam logic [31:0] CNT_LIM = 32'(CNT_MAX);

  logic [F-1:0] new_miss;
  logic [31:0]  new_count;
  logic [31:0]  sum;
  logic [31:0]  clamped;
  logic [31:0]  miss_num_q;
  logic         miss_pulse_q;
  logic [F-1:0] miss_vec_q;

  for (genvar g = 0; g < F; g++) begin : g_slot
    miss_slot_fsm #(
      .FLOOR_Y (FLOOR_Y)
    ) u_slot (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Initialize   (Initialize),
      .frame_edge   (bus.frame_clk_rising_edge),
      .fruit_active (bus.fruit_active[g]),
      .fruit_cut    (bus.fruit_cut[g]),
      .fruit_y      (bus.fruit_y[Y_W*g +: Y_W]),
      .new_miss     (new_miss[g])
    );
  end

  // Sum at full width first so the clamp never sees a wrapped value.
  always_comb begin
    new_count = popcount(32'(new_miss));
    sum       = miss_num_q + new_count;
    clamped   = (sum > CNT_LIM) ? CNT_LIM : sum;
  end

  // NOTE: Reset_n clears asynchronously; Initialize is the synchronous
  // new-game clear and outranks a coincident frame edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      miss_num_q   <= '0;
      miss_pulse_q <= 1'b0;
      miss_vec_q   <= '0;
    end else if (Initialize) begin
      miss_num_q   <= '0;
      miss_pulse_q <= 1'b0;
      miss_vec_q   <= '0;
    end else begin
      miss_pulse_q <= 1'b0;
      if (bus.frame_clk_rising_edge) begin
        miss_num_q   <= clamped;
        miss_vec_q   <= new_miss;
        miss_pulse_q <= (new_count != 32'd0);
      end
    end
  end

  assign bus.miss_num   = miss_num_q;
  assign bus.miss_pulse = miss_pulse_q;
  assign bus.miss_vec   = miss_vec_q;

endmodule
